// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// sram_pkg - supply/threshold constants and FSM state type for the column
//            read/write sequencer.                                  Rev 1.0
// ============================================================================
package sram_pkg;

  localparam real VDD = 1.5;
  localparam real VSS = 0.0;
  localparam real VTH = 0.8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_SETUP = 3'd1,
    W_PULSE = 3'd2,
    W_HOLD  = 3'd3,
    R_PULSE = 3'd4,
    RESP    = 3'd5
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_sense_amp.sv
`default_nettype none
// ============================================================================
// sram_sense_amp - registered differential comparator on the read bitlines.
//                                                                   Rev 1.0
// ============================================================================
module sram_sense_amp #(
  parameter real SENSE_MARGIN = 0.3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  real  bl_rd,
  input  real  blb_rd,
  output logic dout,
  output logic err
);

  real diff;

  always_comb diff = bl_rd - blb_rd;

  // Result is held between strobes so the response stage can read it later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= 1'b0;
      err  <= 1'b0;
    end else if (en) begin
      if (diff >= SENSE_MARGIN) begin
        dout <= 1'b1;
        err  <= 1'b0;
      end else if (diff <= -SENSE_MARGIN) begin
        dout <= 1'b0;
        err  <= 1'b0;
      end else begin
        dout <= 1'b0;
        err  <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_col_rw_ctrl.sv
`default_nettype none
// ============================================================================
// sram_col_rw_ctrl - per-column SRAM read/write sequencer: wordline pulses,
//                    write bitline drive and differential read sensing. Rev 1.0
// ============================================================================
module sram_col_rw_ctrl
  import sram_pkg::*;
#(
  parameter int  ROWS         = 16,
  // One spare bit so out-of-range row indices can be presented and rejected.
  parameter int  AW           = $clog2(ROWS + 1),
  parameter int  WR_CYC       = 2,
  parameter int  RD_CYC       = 2,
  parameter real SENSE_MARGIN = 0.3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic            req_wdata,
  output logic            rsp_valid,
  output logic            rsp_rdata,
  output logic            rsp_err,
  output logic [ROWS-1:0] row_wr,
  output logic [ROWS-1:0] row_rd,
  output real             bl_wr,
  output real             blb_wr,
  input  real             bl_rd,
  input  real             blb_rd
);

  localparam int            MAX_CYC = max2(WR_CYC, RD_CYC);
  localparam int            CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_CYC - 1);
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_CYC - 1);

  state_t          state;
  state_t          next_state;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   addr_q;
  logic            we_q;
  logic            wdata_q;
  logic            bad_q;
  logic            accept;
  logic            addr_bad;
  logic [AW-1:0]   addr_sel;
  logic            wdata_sel;
  logic [ROWS-1:0] dec;
  logic            drive_bl;
  logic            sa_en;
  logic            sa_dout;
  logic            sa_err;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && (state == IDLE);
  assign addr_bad  = 32'(req_addr) >= ROWS;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (addr_bad)    next_state = RESP;
          else if (req_we) next_state = W_SETUP;
          else             next_state = R_PULSE;
        end
      end
      W_SETUP: next_state = W_PULSE;
      W_PULSE: if (cnt == '0) next_state = W_HOLD;
      W_HOLD:  next_state = RESP;
      R_PULSE: if (cnt == '0) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (next_state == W_PULSE && state != W_PULSE) begin
      cnt <= WR_LOAD;
    end else if (next_state == R_PULSE && state != R_PULSE) begin
      cnt <= RD_LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= 1'b0;
      bad_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= req_addr;
      we_q    <= req_we;
      wdata_q <= req_wdata;
      bad_q   <= addr_bad;
    end
  end

  // Reads enter their pulse straight from IDLE, before the capture registers load.
  assign addr_sel  = (state == IDLE) ? req_addr  : addr_q;
  assign wdata_sel = (state == IDLE) ? req_wdata : wdata_q;

  for (genvar i = 0; i < ROWS; i++) begin : g_dec
    assign dec[i] = (addr_sel == AW'(i));
  end

  assign drive_bl = (next_state == W_SETUP) || (next_state == W_PULSE) ||
                    (next_state == W_HOLD);

  // Wordlines and bitlines are registered from next_state, so they are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_wr <= '0;
      row_rd <= '0;
      bl_wr  <= VSS;
      blb_wr <= VSS;
    end else begin
      row_wr <= (next_state == W_PULSE) ? dec : '0;
      row_rd <= (next_state == R_PULSE) ? dec : '0;
      if (drive_bl) begin
        bl_wr  <= wdata_sel ? VDD : VSS;
        blb_wr <= wdata_sel ? VSS : VDD;
      end else begin
        bl_wr  <= VSS;
        blb_wr <= VSS;
      end
    end
  end

  assign sa_en = (state == R_PULSE) && (cnt == '0);

  sram_sense_amp #(
    .SENSE_MARGIN (SENSE_MARGIN)
  ) u_sense (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (sa_en),
    .bl_rd  (bl_rd),
    .blb_rd (blb_rd),
    .dout   (sa_dout),
    .err    (sa_err)
  );

  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rsp_valid && !we_q && !bad_q && sa_dout;
  assign rsp_err   = rsp_valid && (bad_q || (!we_q && sa_err));

endmodule
`default_nettype wire

// File: tb/tb_sram_col_rw_ctrl.sv
`default_nettype none
// ============================================================================
// tb_sram_col_rw_ctrl - directed bench with a behavioural column of cells.
//                                                                   Rev 1.0
// ============================================================================
module tb_sram_col_rw_ctrl;

  localparam int  ROWS   = 16;
  localparam int  AW     = 5;
  localparam int  WR_CYC = 2;
  localparam int  RD_CYC = 2;
  localparam real T_VDD  = 1.5;
  localparam real T_VSS  = 0.0;
  localparam real T_VTH  = 0.8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_we = 1'b0;
  logic [AW-1:0]   req_addr = '0;
  logic            req_wdata = 1'b0;
  logic            rsp_valid;
  logic            rsp_rdata;
  logic            rsp_err;
  logic [ROWS-1:0] row_wr;
  logic [ROWS-1:0] row_rd;
  real             bl_wr;
  real             blb_wr;
  real             bl_rd;
  real             blb_rd;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sram_col_rw_ctrl #(
    .ROWS (ROWS), .AW (AW), .WR_CYC (WR_CYC), .RD_CYC (RD_CYC), .SENSE_MARGIN (0.3)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .req_valid (req_valid), .req_ready (req_ready), .req_we (req_we),
    .req_addr (req_addr), .req_wdata (req_wdata),
    .rsp_valid (rsp_valid), .rsp_rdata (rsp_rdata), .rsp_err (rsp_err),
    .row_wr (row_wr), .row_rd (row_rd),
    .bl_wr (bl_wr), .blb_wr (blb_wr), .bl_rd (bl_rd), .blb_rd (blb_rd)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_r(input string name, input real act, input real exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %f expected %f", name, act, exp);
    end
  endtask

  // Column of cells: latch bl_wr level while a write wordline is high.
  logic [ROWS-1:0] cells = 16'h8000;
  logic            ovr = 1'b0;
  real             ovr_bl = 0.0;
  real             ovr_blb = 0.0;

  always @(posedge clk)
    for (int i = 0; i < ROWS; i++)
      if (row_wr[i]) cells[i] <= (bl_wr > T_VTH);

  always_comb begin
    bl_rd  = T_VSS;
    blb_rd = T_VSS;
    for (int i = 0; i < ROWS; i++)
      if (row_rd[i]) begin
        bl_rd  = cells[i] ? T_VDD : T_VSS;
        blb_rd = cells[i] ? T_VSS : T_VDD;
      end
    if (ovr) begin
      bl_rd  = ovr_bl;
      blb_rd = ovr_blb;
    end
  end

  // Continuous invariant monitor, sampled on the falling edge.
  logic [ROWS-1:0] wr_seen = '0;
  logic [ROWS-1:0] rd_seen = '0;
  logic [ROWS-1:0] prev_wr = '0;
  real             prev_bl = 0.0;
  real             prev_blb = 0.0;
  int              wrun = 0;
  int              rrun = 0;
  int              rsp_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      wrun = 0;
      rrun = 0;
    end else begin
      wr_seen |= row_wr;
      rd_seen |= row_rd;
      if (rsp_valid) rsp_cnt++;
      if (row_wr != '0 || row_rd != '0)
        chk("wl_onehot", $countones(row_wr) + $countones(row_rd), 1);
      if (row_wr != '0 || prev_wr != '0) begin
        chk_r("bl_stable", bl_wr, prev_bl);
        chk_r("blb_stable", blb_wr, prev_blb);
      end
      if (row_wr != '0)
        chk("bl_compl", 32'((bl_wr > T_VTH) ^ (blb_wr > T_VTH)), 1);
      if (row_wr != '0) wrun++;
      else if (wrun != 0) begin
        chk("wr_pulse_len", wrun, WR_CYC);
        wrun = 0;
      end
      if (row_rd != '0) rrun++;
      else if (rrun != 0) begin
        chk("rd_pulse_len", rrun, RD_CYC);
        rrun = 0;
      end
    end
    prev_wr  = row_wr;
    prev_bl  = bl_wr;
    prev_blb = blb_wr;
  end

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic          wdata;
    logic          ovr;
    int            bl_mv;
    int            blb_mv;
    int            lat;
    logic          rdata;
    logic          err;
  } vec_t;

  function automatic vec_t mk(input logic we, input int addr, input logic wd, input logic ov,
                              input int bl, input int blb, input int lat,
                              input logic rd, input logic er);
    vec_t v;
    v.we = we; v.addr = AW'(addr); v.wdata = wd; v.ovr = ov;
    v.bl_mv = bl; v.blb_mv = blb; v.lat = lat; v.rdata = rd; v.err = er;
    return v;
  endfunction

  task automatic run_req(input vec_t v, input string tag);
    bit   seen;
    int   lat;
    logic rd;
    logic er;
    seen = 0; lat = 0; rd = 1'b0; er = 1'b0;
    ovr     = v.ovr;
    ovr_bl  = real'(v.bl_mv) / 1000.0;
    ovr_blb = real'(v.blb_mv) / 1000.0;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(req_ready), 1);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1; lat = c; rd = rsp_rdata; er = rsp_err;
      end
    end
    chk({tag, "_seen"}, 32'(seen), 1);
    if (seen) begin
      chk({tag, "_lat"}, lat, v.lat);
      chk({tag, "_rdata"}, 32'(rd), 32'(v.rdata));
      chk({tag, "_err"}, 32'(er), 32'(v.err));
      @(negedge clk);
      chk({tag, "_strobe1"}, 32'(rsp_valid), 0);
    end
    ovr = 1'b0;
  endtask

  vec_t vecs[12];
  vec_t seq[4];

  initial begin
    int rsp_base;
    int k;
    int got;
    bit just_acc;

    vecs[0]  = mk(1, 3,  1, 0, 0,    0,    5, 0, 0);   // write 1 -> row 3
    vecs[1]  = mk(0, 3,  0, 0, 0,    0,    3, 1, 0);   // read row 3
    vecs[2]  = mk(1, 15, 0, 0, 0,    0,    5, 0, 0);   // write 0 -> row 15 (was 1)
    vecs[3]  = mk(1, 0,  1, 0, 0,    0,    5, 0, 0);   // write 1 -> row 0
    vecs[4]  = mk(0, 15, 0, 0, 0,    0,    3, 0, 0);
    vecs[5]  = mk(0, 0,  0, 0, 0,    0,    3, 1, 0);
    vecs[6]  = mk(0, 3,  0, 1, 800,  700,  3, 0, 1);   // weak differential
    vecs[7]  = mk(0, 16, 0, 0, 0,    0,    1, 0, 1);   // bad address read
    vecs[8]  = mk(1, 16, 1, 0, 0,    0,    1, 0, 1);   // bad address write
    vecs[9]  = mk(0, 3,  0, 1, 1000, 700,  3, 1, 0);   // just above +margin
    vecs[10] = mk(0, 3,  0, 1, 700,  1000, 3, 0, 0);   // just below -margin
    vecs[11] = mk(0, 3,  0, 1, 900,  700,  3, 0, 1);   // 0.2 V, inside margin

    // Reset state
    #12;
    chk("rst_row_wr", row_wr, 0);
    chk("rst_row_rd", row_rd, 0);
    chk_r("rst_bl_wr", bl_wr, 0.0);
    chk_r("rst_blb_wr", blb_wr, 0.0);
    chk("rst_rsp", {rsp_valid, rsp_rdata, rsp_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_ready", 32'(req_ready), 1);

    for (int i = 0; i < 12; i++) run_req(vecs[i], $sformatf("vec%0d", i));
    chk("wr_rows_touched", wr_seen, 16'h8009);
    chk("rd_rows_touched", rd_seen, 16'h8009);

    // Reset during the second write-pulse cycle
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = AW'(5); req_wdata = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("abort_pre_wl", row_wr, 16'h0020);
    chk_r("abort_pre_bl", bl_wr, 1.5);
    rsp_base = rsp_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_row_wr", row_wr, 0);
    chk_r("abort_bl_wr", bl_wr, 0.0);
    chk_r("abort_blb_wr", blb_wr, 0.0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("abort_ready", 32'(req_ready), 1);
    repeat (8) @(negedge clk);
    chk("abort_no_rsp", rsp_cnt - rsp_base, 0);

    // Back-to-back: valid held high across four requests
    seq[0] = mk(1, 7, 1, 0, 0, 0, 0, 0, 0);
    seq[1] = mk(0, 7, 0, 0, 0, 0, 0, 1, 0);
    seq[2] = mk(1, 7, 0, 0, 0, 0, 0, 0, 0);
    seq[3] = mk(0, 7, 0, 0, 0, 0, 0, 0, 0);
    rsp_base = rsp_cnt;
    k = 0; got = 0; just_acc = 0;
    for (int c = 0; c < 80 && got < 4; c++) begin
      @(negedge clk);
      if (just_acc) chk("b2b_busy_ready", 32'(req_ready), 0);
      just_acc = 0;
      if (rsp_valid) begin
        if (got < 4) begin
          chk($sformatf("b2b_rdata%0d", got), 32'(rsp_rdata), 32'(seq[got].rdata));
          chk($sformatf("b2b_err%0d", got), 32'(rsp_err), 0);
        end
        got++;
      end
      if (req_ready && k < 4) begin
        req_valid = 1'b1; req_we = seq[k].we; req_addr = seq[k].addr;
        req_wdata = seq[k].wdata;
        k++;
        just_acc = 1;
      end
    end
    req_valid = 1'b0;
    chk("b2b_accepted", k, 4);
    chk("b2b_responses", got, 4);
    repeat (6) @(negedge clk);
    chk("b2b_rsp_total", rsp_cnt - rsp_base, 4);
    chk("b2b_idle_ready", 32'(req_ready), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
